// File: rtl/bubble_sort_if.sv
// Bundle for the bubble-sort controller: host control (Go/N), data RAM port
// and sorted-stream outputs.
//   master : the controller (drives RAM address/write, Busy, stream, Done)
//   slave  : host + RAM side (drives Go, N, Mem_Rdata)
interface bubble_sort_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5
);
  logic              Go;
  logic [5:0]        N;
  logic [ADDR_W-1:0] Mem_Addr;
  logic              Mem_We;
  logic [DATA_W-1:0] Mem_Wdata;
  logic [DATA_W-1:0] Mem_Rdata;
  logic              Busy;
  logic [DATA_W-1:0] Sorted_Data;
  logic              Out_Valid;
  logic              Done;

  modport master (
    input  Go, N, Mem_Rdata,
    output Mem_Addr, Mem_We, Mem_Wdata, Busy, Sorted_Data, Out_Valid, Done
  );

  modport slave (
    output Go, N, Mem_Rdata,
    input  Mem_Addr, Mem_We, Mem_Wdata, Busy, Sorted_Data, Out_Valid, Done
  );
endinterface

// File: rtl/bubble_sort_ctrl.sv
// In-place bubble sort sequencer for a single-port, sync-read RAM, followed
// by an ascending stream-out of the sorted words.
// Ports:
//   Clk  - rising-edge clock
//   Rst  - synchronous, active-high reset
//   bus  - bubble_sort_if.master: Go/N in, Mem_* RAM port, Busy,
//          Sorted_Data/Out_Valid stream, Done pulse
module bubble_sort_ctrl #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 32
) (
  input  logic          Clk,
  input  logic          Rst,
  bubble_sort_if.master bus
);
  // One extra bit so a count of DEPTH (and j/p/k reaching it) never wraps.
  localparam int CW = ADDR_W + 1;

  typedef enum logic [3:0] {
    IDLE, RDA, RDB, CMP, WRA, WRB, NEXT, OUTP, DRAIN, DONE
  } state_t;

  state_t            state, state_nx;
  logic [CW-1:0]     nc, j, p, k;
  logic [CW-1:0]     n_clip, last_j;
  logic              pass_last, pass_end_out;
  logic [DATA_W-1:0] a, b, sd_hold;
  logic              swapped, ov;

  assign n_clip       = (int'(bus.N) > DEPTH) ? CW'(DEPTH) : CW'(bus.N);
  // Final j of the current pass; valid only while sorting (nc >= 2, p <= nc-2).
  assign last_j       = nc - CW'(2) - p;
  assign pass_last    = (p == nc - CW'(2));
  // Early exit on a clean pass, or after the final pass.
  assign pass_end_out = !swapped || pass_last;

  // State register
  always_ff @(posedge Clk) begin
    if (Rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  if (bus.Go) state_nx = (n_clip <= CW'(1)) ? OUTP : RDA;
      RDA:   state_nx = RDB;
      RDB:   state_nx = CMP;
      // M[j+1] is on the read port this cycle; A already holds M[j].
      CMP:   state_nx = (a > bus.Mem_Rdata) ? WRA : NEXT;
      WRA:   state_nx = WRB;
      WRB:   state_nx = NEXT;
      NEXT:  begin
        if (j < last_j)    state_nx = RDA;
        else if (pass_end_out) state_nx = OUTP;
        else               state_nx = RDA;
      end
      OUTP:  begin
        if (nc == '0)                 state_nx = DONE;
        else if (k == nc - CW'(1))    state_nx = DRAIN;
      end
      DRAIN: state_nx = DONE;
      DONE:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Counters, compare/swap registers and stream register
  always_ff @(posedge Clk) begin
    if (Rst) begin
      nc      <= '0;
      j       <= '0;
      p       <= '0;
      k       <= '0;
      a       <= '0;
      b       <= '0;
      swapped <= 1'b0;
      ov      <= 1'b0;
      sd_hold <= '0;
    end else begin
      case (state)
        IDLE: if (bus.Go) begin
          nc      <= n_clip;
          j       <= '0;
          p       <= '0;
          k       <= '0;
          swapped <= 1'b0;
        end
        RDB:  a <= bus.Mem_Rdata;
        CMP:  b <= bus.Mem_Rdata;
        WRA:  swapped <= 1'b1;
        NEXT: begin
          if (j < last_j) j <= j + CW'(1);
          else if (!pass_end_out) begin
            p       <= p + CW'(1);
            j       <= '0;
            swapped <= 1'b0;
          end
        end
        OUTP: k <= k + CW'(1);
        default: ;
      endcase
      // Valid lands the cycle the RAM presents the word for the OUTP address.
      ov <= (state == OUTP) && (nc != '0);
      if (ov) sd_hold <= bus.Mem_Rdata;
    end
  end

  // Stream word: live RAM data while valid, otherwise the last word shown.
  assign bus.Sorted_Data = ov ? bus.Mem_Rdata : sd_hold;
  assign bus.Out_Valid   = ov;

  // Output logic
  always_comb begin
    bus.Mem_Addr  = '0;
    bus.Mem_We    = 1'b0;
    bus.Mem_Wdata = '0;
    bus.Busy      = (state != IDLE);
    bus.Done      = (state == DONE);
    case (state)
      RDA:  bus.Mem_Addr = j[ADDR_W-1:0];
      RDB:  bus.Mem_Addr = ADDR_W'(j + CW'(1));
      WRA:  begin
        bus.Mem_Addr  = j[ADDR_W-1:0];
        bus.Mem_We    = 1'b1;
        bus.Mem_Wdata = b;
      end
      WRB:  begin
        bus.Mem_Addr  = ADDR_W'(j + CW'(1));
        bus.Mem_We    = 1'b1;
        bus.Mem_Wdata = a;
      end
      OUTP: bus.Mem_Addr = k[ADDR_W-1:0];
      default: ;
    endcase
  end
endmodule

// File: tb/tb_bubble_sort_ctrl.sv
// Directed bench for bubble_sort_ctrl with a behavioural sync-read RAM.
module tb_bubble_sort_ctrl;
  logic Clk = 1'b0;
  logic Rst;
  always #5 Clk = ~Clk;

  bubble_sort_if #(.DATA_W(8), .ADDR_W(5)) bus ();

  bubble_sort_ctrl #(.DATA_W(8), .ADDR_W(5), .DEPTH(32)) dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus)
  );

  // RAM model: bench preload port has priority over the DUT write port.
  logic [7:0] mem [32];
  logic       ld_en;
  logic [4:0] ld_addr;
  logic [7:0] ld_data;
  always @(posedge Clk) begin
    if (ld_en)           mem[ld_addr]      <= ld_data;
    else if (bus.Mem_We) mem[bus.Mem_Addr] <= bus.Mem_Wdata;
    bus.Mem_Rdata <= mem[bus.Mem_Addr];
  end

  // Monitor
  int         cyc = 0;
  int         done_cnt = 0;
  int         we_cnt = 0;
  logic [7:0] vq[$];
  int         vc[$];
  always @(negedge Clk) begin
    cyc++;
    if (bus.Out_Valid) begin
      vq.push_back(bus.Sorted_Data);
      vc.push_back(cyc);
    end
    if (bus.Done)   done_cnt++;
    if (bus.Mem_We) we_cnt++;
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic wr(input int ad, input int d);
    @(negedge Clk); #1;
    ld_en = 1'b1; ld_addr = 5'(ad); ld_data = 8'(d);
  endtask

  task automatic ld_off();
    @(negedge Clk); #1;
    ld_en = 1'b0;
  endtask

  task automatic load4(input int d0, input int d1, input int d2, input int d3);
    wr(0, d0); wr(1, d1); wr(2, d2); wr(3, d3);
    ld_off();
  endtask

  task automatic start(input int n, output int go_cyc, output int vbase);
    @(negedge Clk); #1;
    go_cyc = cyc;
    vbase  = vq.size();
    bus.N  = 6'(n);
    bus.Go = 1'b1;
    @(negedge Clk); #1;
    bus.Go = 1'b0;
  endtask

  task automatic wait_done(input int bound, output int dcyc, output int gaps);
    int c = 0;
    dcyc = -1;
    gaps = 0;
    while (c < bound) begin
      @(negedge Clk); #1;
      c++;
      if (bus.Done) begin
        dcyc = cyc;
        break;
      end
      if (!bus.Busy) gaps++;
    end
    chk("done_seen", (dcyc >= 0), 1);
  endtask

  task automatic chk4(input string tag, input int vbase,
                      input int e0, input int e1, input int e2, input int e3);
    int e[4];
    e = '{e0, e1, e2, e3};
    chk({tag, "_cnt"}, vq.size() - vbase, 4);
    if (vq.size() - vbase >= 4)
      for (int i = 0; i < 4; i++)
        chk($sformatf("%s_w%0d", tag, i), vq[vbase+i], e[i]);
  endtask

  task automatic chk_ramp32(input string tag, input int vbase);
    chk({tag, "_cnt"}, vq.size() - vbase, 32);
    if (vq.size() - vbase >= 32)
      for (int i = 0; i < 32; i++)
        chk($sformatf("%s_w%0d", tag, i), vq[vbase+i], i);
  endtask

  task automatic chk_idle_outs(input string tag);
    chk({tag, "_addr"},  bus.Mem_Addr,    0);
    chk({tag, "_we"},    bus.Mem_We,      0);
    chk({tag, "_wdata"}, bus.Mem_Wdata,   0);
    chk({tag, "_sdata"}, bus.Sorted_Data, 0);
    chk({tag, "_ovld"},  bus.Out_Valid,   0);
    chk({tag, "_busy"},  bus.Busy,        0);
    chk({tag, "_done"},  bus.Done,        0);
  endtask

  initial begin
    int go_c, vb, dc, gaps, we0, d0, last;
    Rst = 1'b1; bus.Go = 1'b0; bus.N = '0;
    ld_en = 1'b0; ld_addr = '0; ld_data = '0;
    repeat (3) @(negedge Clk);
    #1;
    chk_idle_outs("reset");
    Rst = 1'b0;

    // T1: basic sort and Done timing
    load4(5, 3, 8, 1);
    we0 = we_cnt; d0 = done_cnt;
    start(4, go_c, vb);
    wait_done(200, dc, gaps);
    chk4("t1", vb, 1, 3, 5, 8);
    last = vc.size() - 1;
    if (vq.size() - vb >= 4) begin
      chk("t1_contig", vc[last] - vc[vb], 3);
      chk("t1_done_after_last", dc - vc[last], 1);
    end
    chk("t1_writes", we_cnt - we0, 8);
    chk("t1_done_cnt", done_cnt - d0, 1);
    @(negedge Clk); #1;
    chk("t1_busy_after", bus.Busy, 0);
    chk("t1_sdata_hold", bus.Sorted_Data, 8);

    // Unsigned compare with duplicates
    load4(200, 7, 200, 0);
    start(4, go_c, vb);
    wait_done(200, dc, gaps);
    chk4("uns", vb, 0, 7, 200, 200);

    // T2: already sorted -> single pass, no writes
    for (int i = 0; i < 32; i++) wr(i, i);
    ld_off();
    we0 = we_cnt;
    start(32, go_c, vb);
    wait_done(400, dc, gaps);
    chk("t2_writes", we_cnt - we0, 0);
    if (vc.size() > vb) chk("t2_first_valid", vc[vb] - go_c, 126);
    chk("t2_done_lat", dc - go_c, 158);
    chk_ramp32("t2", vb);

    // T3: reversed -> 496 swaps, Busy continuous
    for (int i = 0; i < 32; i++) wr(i, 31 - i);
    ld_off();
    we0 = we_cnt; d0 = done_cnt;
    start(32, go_c, vb);
    wait_done(5000, dc, gaps);
    chk("t3_busy_gaps", gaps, 0);
    chk("t3_busy_at_done", bus.Busy, 1);
    chk("t3_writes", we_cnt - we0, 992);
    chk("t3_done_cnt", done_cnt - d0, 1);
    chk_ramp32("t3", vb);

    // T4: N=0, N=1, N=40
    start(0, go_c, vb);
    wait_done(10, dc, gaps);
    chk("t4_n0_done_lat", dc - go_c, 2);
    chk("t4_n0_words", vq.size() - vb, 0);

    wr(0, 8'h5A); ld_off();
    start(1, go_c, vb);
    wait_done(20, dc, gaps);
    chk("t4_n1_cnt", vq.size() - vb, 1);
    if (vq.size() > vb) begin
      chk("t4_n1_word", vq[vb], 8'h5A);
      chk("t4_n1_done_after", dc - vc[vb], 1);
    end

    for (int i = 0; i < 32; i++) wr(i, (i * 5) % 32);
    ld_off();
    start(40, go_c, vb);
    wait_done(5000, dc, gaps);
    chk_ramp32("t4_n40", vb);

    // T5: Go during compare phase and in the DONE cycle
    load4(5, 3, 8, 1);
    d0 = done_cnt;
    start(4, go_c, vb);
    repeat (4) @(negedge Clk);
    #1;
    bus.Go = 1'b1; bus.N = 6'd2;
    @(negedge Clk); #1;
    bus.Go = 1'b0;
    wait_done(200, dc, gaps);
    bus.Go = 1'b1; bus.N = 6'd4;
    @(negedge Clk); #1;
    bus.Go = 1'b0;
    chk("t5_busy_idle", bus.Busy, 0);
    repeat (10) @(negedge Clk);
    #1;
    chk("t5_done_cnt", done_cnt - d0, 1);
    chk("t5_busy_end", bus.Busy, 0);
    chk4("t5", vb, 1, 3, 5, 8);

    // T6: reset during the first write, then re-sort
    load4(5, 3, 8, 1);
    d0 = done_cnt;
    start(4, go_c, vb);
    begin
      int c = 0;
      while (c < 50 && !bus.Mem_We) begin
        @(negedge Clk); #1;
        c++;
      end
    end
    chk("t6_wra_seen", bus.Mem_We, 1);
    Rst = 1'b1;
    @(negedge Clk); #1;
    chk_idle_outs("t6_rst");
    Rst = 1'b0;
    chk("t6_no_done", done_cnt - d0, 0);
    start(4, go_c, vb);
    wait_done(200, dc, gaps);
    chk4("t6", vb, 1, 3, 3, 8);
    chk("t6_done_cnt", done_cnt - d0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
